keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Input-side counterpart of the multiplexed 7-segment display driver: scans a 4x4
//  matrix keypad (Pmod KYPD style), synchronises and debounces the row lines, and
//  reports each new key press once as a 4-bit hex code with a single-cycle strobe.
//  It sits between the board keypad pins and the game's digit-entry logic.
//  It drives active-low column strobes, just as the display driver drives active-low AN.
// PARAMETERS
//  DWELL_CYCLES    100000  clk cycles each column is held low (1 ms @ 100 MHz); >=4
//  DEBOUNCE_SCANS  4       consecutive matching samples required to accept press/release; >=1
// PORTS
//  clk        in   1  system clock (100 MHz)
//  resetb     in   1  synchronous reset, active low
//  ROW        in   4  keypad rows, active low (pulled up on board), asynchronous
//  COL        out  4  keypad column strobes, active low, exactly one bit low at all times
//  key_valid  out  1  one-cycle pulse: new debounced key press accepted
//  key_code   out  4  code of last accepted key; valid from key_valid until next press
//  key_held   out  1  high while accepted key is held (press accepted -> release accepted)
// BEHAVIOUR
//  Reset (resetb=0 at a clk edge): COL=4'b1110, key_valid=0, key_code=0, key_held=0,
//   state=SCAN, dwell/debounce counters=0, synchroniser flops=4'b1111. Applies mid-scan/mid-hold.
//  ROW passes through a 2-flop synchroniser; only the synchronised value (rs) is used.
//  Dwell counter: counts 0..DWELL_CYCLES-1 then wraps; "sample point" = cycle count==DWELL_CYCLES-1.
//   Rows are evaluated only at sample points (>=2 cycles after a COL change for settling).
//  Key map (col c, row r) -> code: c0:1,4,7,0  c1:2,5,8,F  c2:3,6,9,E  c3:A,B,C,D (r0..r3).
//  Row priority: if several rows low in one column, the lowest row index wins.
//  FSM:
//   SCAN    : at sample point, if rs!=4'hF -> latch cand=(col,row), deb=1; if DEBOUNCE_SCANS==1
//             accept immediately, else go CONFIRM; COL stays on the current column.
//             If rs==4'hF -> rotate COL left (1110->1101->1011->0111->1110 wrap).
//   CONFIRM : COL frozen. At sample point: same row still low -> deb++; when deb reaches
//             DEBOUNCE_SCANS -> accept. Row high or a different row wins -> discard cand, rotate COL, SCAN.
//   accept  : on the cycle after the deciding sample point: key_valid=1 for exactly 1 cycle,
//             key_code=map(cand), key_held=1, deb=0, state=HELD.
//   HELD    : COL frozen on the accepted column. At sample point: cand row high -> deb++,
//             cand row low -> deb=0. deb reaches DEBOUNCE_SCANS -> key_held=0 on the next cycle,
//             rotate COL, SCAN. No auto-repeat; other keys are ignored while HELD.
//  Latency: press stable before a sample point -> key_valid exactly
//   (DEBOUNCE_SCANS-1)*DWELL_CYCLES+1 cycles after that first sample point.
//  key_code holds its value after release; it changes only on accept.
//  COL never has 0 or >1 low bits; the dwell counter runs continuously in all states.
// TESTING (sim params DWELL_CYCLES=4, DEBOUNCE_SCANS=3)
//  1 Reset, ROW=F for 64 cycles -> COL cycles 1110,1101,1011,0111,1110 every 4 cycles; key_valid never 1.
//  2 ROW=1110 while COL=1101, held 40 cycles -> one key_valid pulse, key_code=2, key_held=1, COL frozen 1101.
//  3 From test 2 release ROW=F -> key_held falls 9 cycles after first high sample; scan resumes at 1011.
//  4 Bounce: ROW low for 1 sample, high for next while COL=0111 -> no key_valid; COL moves to 1110.
//  5 ROW=1010 (rows 0,2) during COL=1110 -> key_code=1 (row 0 wins); single key_valid.
//  6 resetb=0 one cycle while HELD -> next cycle COL=1110, key_held=0, key_code=0, key_valid=0.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad pin bundle plus the debounced key report, shared by the scanner and its consumer.
// The master side is the scanner; the slave side is the board/digit-entry logic.
interface keypad_scanner_if;
   logic [3:0] ROW;
   logic [3:0] COL;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_held;

   modport master (
      input  ROW,
      output COL,
      output key_valid,
      output key_code,
      output key_held
   );

   modport slave (
      output ROW,
      input  COL,
      input  key_valid,
      input  key_code,
      input  key_held
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: active-low column strobes, synchronised and debounced rows,
// one-cycle strobe per accepted press and a held flag until the release is debounced.
module keypad_scanner #(
   parameter int DWELL_CYCLES   = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic              clk,
   input  logic              resetb,
   keypad_scanner_if.master  kif
);

   localparam int DW_W  = $clog2(DWELL_CYCLES);
   localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
   localparam logic [DW_W-1:0]  DWELL_ONE  = DW_W'(1);
   localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_SCANS - 1);
   localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(1);
   localparam logic [3:0]       COL_FIRST  = 4'b1110;

   typedef enum logic [1:0] {
      ST_SCAN    = 2'd0,
      ST_CONFIRM = 2'd1,
      ST_HELD    = 2'd2
   } state_t;

   function automatic logic [1:0] col_index(input logic [3:0] col);
      case (col)
         4'b1110: col_index = 2'd0;
         4'b1101: col_index = 2'd1;
         4'b1011: col_index = 2'd2;
         4'b0111: col_index = 2'd3;
         default: col_index = 2'd0;
      endcase
   endfunction

   function automatic logic col_ok(input logic [3:0] col);
      case (col)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: col_ok = 1'b1;
         default:                            col_ok = 1'b0;
      endcase
   endfunction

   // Lowest-numbered low row wins when several keys share a column.
   function automatic logic [1:0] first_low_row(input logic [3:0] rows);
      if (!rows[0]) begin
         first_low_row = 2'd0;
      end else if (!rows[1]) begin
         first_low_row = 2'd1;
      end else if (!rows[2]) begin
         first_low_row = 2'd2;
      end else begin
         first_low_row = 2'd3;
      end
   endfunction

   function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
      case ({c, r})
         4'b00_00: key_map = 4'h1;
         4'b00_01: key_map = 4'h4;
         4'b00_10: key_map = 4'h7;
         4'b00_11: key_map = 4'h0;
         4'b01_00: key_map = 4'h2;
         4'b01_01: key_map = 4'h5;
         4'b01_10: key_map = 4'h8;
         4'b01_11: key_map = 4'hF;
         4'b10_00: key_map = 4'h3;
         4'b10_01: key_map = 4'h6;
         4'b10_10: key_map = 4'h9;
         4'b10_11: key_map = 4'hE;
         4'b11_00: key_map = 4'hA;
         4'b11_01: key_map = 4'hB;
         4'b11_10: key_map = 4'hC;
         4'b11_11: key_map = 4'hD;
         default:  key_map = 4'h0;
      endcase
   endfunction

   state_t            state_q, state_d;
   logic [3:0]        sync1_q, sync1_d;
   logic [3:0]        rs_q, rs_d;
   logic [DW_W-1:0]   dwell_q, dwell_d;
   logic [DEB_W-1:0]  deb_q, deb_d;
   logic [3:0]        col_q, col_d;
   logic [1:0]        cand_col_q, cand_col_d;
   logic [1:0]        cand_row_q, cand_row_d;
   logic              key_valid_q, key_valid_d;
   logic [3:0]        key_code_q, key_code_d;
   logic              key_held_q, key_held_d;

   logic              sample_s;
   logic              any_low_s;
   logic [1:0]        row_s;
   logic [3:0]        col_next_s;

   // Next-state computation for the synchroniser, dwell timer and scan/debounce FSM.
   always_comb begin
      state_d     = state_q;
      sync1_d     = kif.ROW;
      rs_d        = sync1_q;
      deb_d       = deb_q;
      col_next_s  = col_q;
      cand_col_d  = cand_col_q;
      cand_row_d  = cand_row_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      key_held_d  = key_held_q;

      sample_s  = (dwell_q == DWELL_LAST);
      any_low_s = (rs_q != 4'hF);
      row_s     = first_low_row(rs_q);
      dwell_d   = sample_s ? '0 : dwell_q + DWELL_ONE;

      case (state_q)
         ST_SCAN: begin
            if (sample_s && any_low_s) begin
               cand_col_d = col_index(col_q);
               cand_row_d = row_s;
               if (DEBOUNCE_SCANS == 1) begin
                  key_valid_d = 1'b1;
                  key_code_d  = key_map(col_index(col_q), row_s);
                  key_held_d  = 1'b1;
                  deb_d       = '0;
                  state_d     = ST_HELD;
               end else begin
                  deb_d   = DEB_ONE;
                  state_d = ST_CONFIRM;
               end
            end else if (sample_s) begin
               col_next_s = {col_q[2:0], col_q[3]};
            end else begin
               col_next_s = col_q;
            end
         end
         ST_CONFIRM: begin
            if (sample_s && any_low_s && (row_s == cand_row_q)) begin
               if (deb_q == DEB_LAST) begin
                  key_valid_d = 1'b1;
                  key_code_d  = key_map(cand_col_q, cand_row_q);
                  key_held_d  = 1'b1;
                  deb_d       = '0;
                  state_d     = ST_HELD;
               end else begin
                  deb_d = deb_q + DEB_ONE;
               end
            end else if (sample_s) begin
               deb_d      = '0;
               col_next_s = {col_q[2:0], col_q[3]};
               state_d    = ST_SCAN;
            end else begin
               deb_d = deb_q;
            end
         end
         ST_HELD: begin
            // Other keys are ignored here: only the accepted row is watched for release.
            if (sample_s && rs_q[cand_row_q]) begin
               if (deb_q == DEB_LAST) begin
                  key_held_d = 1'b0;
                  deb_d      = '0;
                  col_next_s = {col_q[2:0], col_q[3]};
                  state_d    = ST_SCAN;
               end else begin
                  deb_d = deb_q + DEB_ONE;
               end
            end else if (sample_s) begin
               deb_d = '0;
            end else begin
               deb_d = deb_q;
            end
         end
         default: begin
            state_d    = ST_SCAN;
            deb_d      = '0;
            key_held_d = 1'b0;
            col_next_s = COL_FIRST;
         end
      endcase

      // A corrupted strobe pattern is forced back to a legal single-low column.
      col_d = col_ok(col_next_s) ? col_next_s : COL_FIRST;
   end

   // State, counters, synchroniser and registered outputs with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         state_q     <= ST_SCAN;
         sync1_q     <= 4'hF;
         rs_q        <= 4'hF;
         dwell_q     <= '0;
         deb_q       <= '0;
         col_q       <= COL_FIRST;
         cand_col_q  <= 2'd0;
         cand_row_q  <= 2'd0;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         rs_q        <= rs_d;
         dwell_q     <= dwell_d;
         deb_q       <= deb_d;
         col_q       <= col_d;
         cand_col_q  <= cand_col_d;
         cand_row_q  <= cand_row_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         key_held_q  <= key_held_d;
      end
   end

   assign kif.COL       = col_q;
   assign kif.key_valid = key_valid_q;
   assign kif.key_code  = key_code_q;
   assign kif.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (DWELL_CYCLES=4, DEBOUNCE_SCANS=3) with a 4x4 keypad model.
module tb_keypad_scanner;

   logic        clk;
   logic        resetb;
   logic [15:0] pressed;
   logic [3:0]  row_m;
   int          vectors;
   int          miscompares;
   int          k;

   keypad_scanner_if kif ();

   keypad_scanner #(
      .DWELL_CYCLES   (4),
      .DEBOUNCE_SCANS (3)
   ) dut (
      .clk    (clk),
      .resetb (resetb),
      .kif    (kif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Key (c,r) is pressed[c*4+r]; a pressed key pulls its row low while its column is strobed.
   always_comb begin
      row_m = 4'hF;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (pressed[c*4 + r] && !kif.COL[c]) row_m[r] = 1'b0;
         end
      end
   end
   assign kif.ROW = row_m;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s at cycle %0d: observed %b expected %b", tag, k, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      k++;
   endtask

   task automatic wait_to(input int t);
      while (k < t) tick();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      k           = 0;
      pressed     = 16'h0000;
      resetb      = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetb = 1'b1;

      chk("reset_col",   kif.COL, 4'b1110);
      chk("reset_valid", {3'b000, kif.key_valid}, 4'h0);
      chk("reset_code",  kif.key_code, 4'h0);
      chk("reset_held",  {3'b000, kif.key_held}, 4'h0);

      // Idle scan: column advances every 4 cycles, never a key strobe.
      for (int i = 0; i < 64; i++) begin
         chk("idle_col",   kif.COL, ~(4'b0001 << ((i / 4) % 4)));
         chk("idle_valid", {3'b000, kif.key_valid}, 4'h0);
         tick();
      end

      // Key 2 at col1/row0; first sample on col1 is at edge 72, accept after edge 80.
      pressed[4] = 1'b1;
      while (k < 80) begin
         chk("press_nostrobe", {3'b000, kif.key_valid}, 4'h0);
         tick();
      end
      chk("press_valid", {3'b000, kif.key_valid}, 4'h1);
      chk("press_code",  kif.key_code, 4'h2);
      chk("press_held",  {3'b000, kif.key_held}, 4'h1);
      chk("press_col",   kif.COL, 4'b1101);
      tick();
      while (k < 104) begin
         chk("hold_valid", {3'b000, kif.key_valid}, 4'h0);
         chk("hold_held",  {3'b000, kif.key_held}, 4'h1);
         chk("hold_col",   kif.COL, 4'b1101);
         tick();
      end

      // Release: first high sample at edge 108, held drops after edge 116.
      pressed[4] = 1'b0;
      while (k < 116) begin
         chk("rel_held", {3'b000, kif.key_held}, 4'h1);
         chk("rel_col",  kif.COL, 4'b1101);
         tick();
      end
      chk("rel_held_low", {3'b000, kif.key_held}, 4'h0);
      chk("rel_col_next", kif.COL, 4'b1011);
      chk("rel_code_kept", kif.key_code, 4'h2);
      chk("rel_valid", {3'b000, kif.key_valid}, 4'h0);

      // Bounce on col3: low for the sample at edge 124 only, gone by edge 128.
      wait_to(120);
      chk("bounce_col_start", kif.COL, 4'b0111);
      tick();
      pressed[13] = 1'b1;
      tick();
      pressed[13] = 1'b0;
      while (k < 128) begin
         chk("bounce_valid", {3'b000, kif.key_valid}, 4'h0);
         chk("bounce_col",   kif.COL, 4'b0111);
         tick();
      end
      chk("bounce_col_next", kif.COL, 4'b1110);
      chk("bounce_valid_end", {3'b000, kif.key_valid}, 4'h0);
      chk("bounce_code_kept", kif.key_code, 4'h2);

      // Keys 1 and 7 together on col0: row 0 wins, single strobe after edge 140.
      pressed[0] = 1'b1;
      pressed[2] = 1'b1;
      while (k < 150) begin
         if (k == 140) begin
            chk("multi_valid", {3'b000, kif.key_valid}, 4'h1);
            chk("multi_code",  kif.key_code, 4'h1);
            chk("multi_held",  {3'b000, kif.key_held}, 4'h1);
         end else begin
            chk("multi_single", {3'b000, kif.key_valid}, 4'h0);
         end
         tick();
      end
      chk("pre_reset_held", {3'b000, kif.key_held}, 4'h1);
      chk("pre_reset_col",  kif.COL, 4'b1110);

      // Reset while held.
      resetb = 1'b0;
      tick();
      chk("midreset_col",   kif.COL, 4'b1110);
      chk("midreset_held",  {3'b000, kif.key_held}, 4'h0);
      chk("midreset_code",  kif.key_code, 4'h0);
      chk("midreset_valid", {3'b000, kif.key_valid}, 4'h0);
      resetb  = 1'b1;
      pressed = 16'h0000;
      wait_to(154);
      chk("post_reset_col0", kif.COL, 4'b1110);
      tick();
      chk("post_reset_col1", kif.COL, 4'b1101);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
